// File: rtl/sum_product_pkg.sv
// Shared types and constants for the sum/product unit: FSM state encoding,
// counter sizing helper and reset values.
package sum_product_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit counter must be able to hold WIDTH itself.
  function automatic int cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

  localparam state_e RST_STATE     = IDLE;
  localparam logic   RST_IN_READY  = 1'b1;
  localparam logic   RST_OUT_VALID = 1'b0;
  localparam logic   RST_BUSY      = 1'b0;
  localparam logic   RST_ACC_OVF   = 1'b0;

endpackage

// File: rtl/shift_add_mul.sv
// Iterative unsigned shift-add multiplier, one multiplier bit per clock.
// done_o/product_o are valid combinationally on the final iteration edge.
module shift_add_mul
  import sum_product_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               done_o,
  output logic [2*WIDTH-1:0] product_o
);

  localparam int CW = cnt_w(WIDTH);
  localparam int PW = 2 * WIDTH;

  logic [PW-1:0]    a_q, part_q, part_d;
  logic [WIDTH-1:0] b_q, b_sh;
  logic [CW-1:0]    cnt_q;
  logic             run_q;
  logic             last;

  assign b_sh = b_q >> cnt_q;
  assign last = run_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    part_d = part_q;
    if (b_sh[0]) part_d = part_q + (a_q << cnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q    <= '0;
      b_q    <= '0;
      part_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
    end else if (start_i) begin
      a_q    <= PW'(a_i);
      b_q    <= b_i;
      part_q <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b1;
    end else if (run_q) begin
      part_q <= part_d;
      // Counter parks on the last bit so the b_q select never leaves range.
      if (last) run_q <= 1'b0;
      else      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign done_o    = last;
  assign product_o = part_d;

endmodule

// File: rtl/sum_product_unit.sv
// Handshaked sum/product engine with optional running product accumulator.
// Define SUM_PRODUCT_MON_DISPLAY_EN for simulation accept/completion messages.
module sum_product_unit
  import sum_product_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int ACC_W = 2 * WIDTH
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_acc,
  input  logic               acc_clear,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH:0]     out_sum,
  output logic [2*WIDTH-1:0] out_product,
  output logic [ACC_W-1:0]   out_acc,
  output logic               acc_ovf,
  output logic               busy
);

  state_e state_q, state_d;

  logic [WIDTH:0]     sum_q, sum_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic               ovf_q, ovf_d;
  logic               acc_en_q, acc_en_d;
  logic [ACC_W:0]     acc_sum;
  logic               accept, mul_done;
  logic [2*WIDTH-1:0] mul_product;

  assign accept = in_valid && in_ready;

  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk       (clk),
    .rst       (rst),
    .start_i   (accept),
    .a_i       (in_a),
    .b_i       (in_b),
    .done_o    (mul_done),
    .product_o (mul_product)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= RST_STATE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = BUSY;
      BUSY:    if (mul_done)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
  end

  assign acc_sum = {1'b0, acc_q} + (ACC_W + 1)'(mul_product);

  always_comb begin
    sum_d    = sum_q;
    acc_en_d = acc_en_q;
    prod_d   = prod_q;
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    if (accept) begin
      sum_d    = (WIDTH + 1)'(in_a) + (WIDTH + 1)'(in_b);
      acc_en_d = in_acc;
    end
    if (mul_done) prod_d = mul_product;
    // Clear wins over a same-edge accumulation.
    if (acc_clear) begin
      acc_d = '0;
      ovf_d = 1'b0;
    end else if (mul_done && acc_en_q) begin
      acc_d = acc_sum[ACC_W-1:0];
      if (acc_sum[ACC_W]) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_q    <= '0;
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= RST_ACC_OVF;
      acc_en_q <= 1'b0;
    end else begin
      sum_q    <= sum_d;
      prod_q   <= prod_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      acc_en_q <= acc_en_d;
    end
  end

  assign out_sum     = sum_q;
  assign out_product = prod_q;
  assign out_acc     = acc_q;
  assign acc_ovf     = ovf_q;

`ifdef SUM_PRODUCT_MON_DISPLAY_EN
  always @(posedge clk) begin
    if (!rst) begin
      if (accept)
        $display("SPU accept a=%0d b=%0d acc=%0d", in_a, in_b, in_acc);
      if (mul_done)
        $display("SPU done sum=%0d product=%0d out_acc=%0d ovf=%0d",
                 sum_q, mul_product, acc_d, ovf_d);
    end
  end
`else
  // Monitor not built; datapath is identical either way.
`endif

endmodule

// File: tb/tb_sum_product_unit.sv
// Directed self-checking bench for sum_product_unit at WIDTH=8, ACC_W=16.
module tb_sum_product_unit;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_acc, acc_clear, out_ready;
  logic        in_ready, out_valid, acc_ovf, busy;
  logic [7:0]  in_a, in_b;
  logic [8:0]  out_sum;
  logic [15:0] out_product, out_acc;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sum_product_unit #(.WIDTH(8), .ACC_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_acc(in_acc), .acc_clear(acc_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_product(out_product), .out_acc(out_acc), .acc_ovf(acc_ovf),
    .busy(busy)
  );

  // Present one operand pair and return 1ns after its accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic acc);
    @(negedge clk);
    in_a = a; in_b = b; in_acc = acc; in_valid = 1'b1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++; $display("FAIL send_ready got %0b want 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges from accept to out_valid, bounded.
  task automatic wait_done(output int lat);
    lat = 0;
    while (out_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; in_acc = 1'b0; acc_clear = 1'b0;
    out_ready = 1'b1; in_a = '0; in_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy, acc_ovf} !== 4'b1000 || out_sum !== 9'd0 ||
        out_product !== 16'd0 || out_acc !== 16'd0) begin
      n_err++;
      $display("FAIL reset_state got rdy=%0b vld=%0b busy=%0b ovf=%0b sum=%0d prod=%0d acc=%0d",
               in_ready, out_valid, busy, acc_ovf, out_sum, out_product, out_acc);
    end
  endtask

  task automatic test_basic();
    int lat;
    send(8'd10, 8'd99, 1'b0);
    n_cmp++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      n_err++; $display("FAIL basic_busy got busy=%0b rdy=%0b want 1/0", busy, in_ready);
    end
    wait_done(lat);
    n_cmp++;
    if (lat != 8) begin n_err++; $display("FAIL basic_latency got %0d want 8", lat); end
    n_cmp++;
    if (out_sum !== 9'd109 || out_product !== 16'd990) begin
      n_err++; $display("FAIL basic_result got %0d/%0d want 109/990", out_sum, out_product);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL basic_release got vld=%0b rdy=%0b busy=%0b", out_valid, in_ready, busy);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    out_ready = 1'b0;
    send(8'd132, 8'd33, 1'b0);
    in_a = 8'd255; in_b = 8'd255;
    wait_done(lat);
    n_cmp++;
    if (lat != 8) begin n_err++; $display("FAIL hold_latency got %0d want 8", lat); end
    in_valid = 1'b1; in_a = 8'd1; in_b = 8'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 9'd165 ||
          out_product !== 16'd4356) begin
        n_err++;
        $display("FAIL hold_stable[%0d] got vld=%0b rdy=%0b sum=%0d prod=%0d want 1/0/165/4356",
                 i, out_valid, in_ready, out_sum, out_product);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || out_sum !== 9'd165) begin
      n_err++;
      $display("FAIL hold_no_turnaround got vld=%0b busy=%0b sum=%0d want 0/0/165",
               out_valid, busy, out_sum);
    end
    in_valid = 1'b0;
  endtask

  task automatic test_accumulate();
    int lat;
    send(8'd255, 8'd255, 1'b1);
    wait_done(lat);
    n_cmp++;
    if (out_product !== 16'd65025 || out_sum !== 9'd510 || out_acc !== 16'd65025 || acc_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL acc_first got prod=%0d sum=%0d acc=%0d ovf=%0b want 65025/510/65025/0",
               out_product, out_sum, out_acc, acc_ovf);
    end
    @(posedge clk); #1;
    send(8'd10, 8'd99, 1'b1);
    wait_done(lat);
    n_cmp++;
    if (out_acc !== 16'd479 || acc_ovf !== 1'b1) begin
      n_err++; $display("FAIL acc_wrap got acc=%0d ovf=%0b want 479/1", out_acc, acc_ovf);
    end
    @(posedge clk); #1;
    acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    n_cmp++;
    if (out_acc !== 16'd0 || acc_ovf !== 1'b0) begin
      n_err++; $display("FAIL acc_clear got acc=%0d ovf=%0b want 0/0", out_acc, acc_ovf);
    end
  endtask

  task automatic test_clear_priority();
    int lat;
    send(8'd2, 8'd3, 1'b1);
    wait_done(lat);
    n_cmp++;
    if (out_acc !== 16'd6) begin n_err++; $display("FAIL prio_setup got %0d want 6", out_acc); end
    @(posedge clk); #1;
    send(8'd4, 8'd4, 1'b1);
    repeat (7) @(posedge clk);
    #1 acc_clear = 1'b1;
    @(posedge clk); #1;
    acc_clear = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b1 || out_product !== 16'd16 || out_acc !== 16'd0 || acc_ovf !== 1'b0) begin
      n_err++;
      $display("FAIL prio_clear got vld=%0b prod=%0d acc=%0d ovf=%0b want 1/16/0/0",
               out_valid, out_product, out_acc, acc_ovf);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    int lat;
    send(8'd5, 8'd5, 1'b1);
    wait_done(lat);
    @(posedge clk); #1;
    n_cmp++;
    if (out_acc !== 16'd25) begin n_err++; $display("FAIL abort_setup got %0d want 25", out_acc); end
    send(8'd10, 8'd99, 1'b1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++;
    if ({in_ready, out_valid, busy, acc_ovf} !== 4'b1000 || out_sum !== 9'd0 ||
        out_product !== 16'd0 || out_acc !== 16'd0) begin
      n_err++;
      $display("FAIL abort_reset got rdy=%0b vld=%0b busy=%0b ovf=%0b sum=%0d prod=%0d acc=%0d",
               in_ready, out_valid, busy, acc_ovf, out_sum, out_product, out_acc);
    end
    send(8'd4, 8'd3, 1'b0);
    wait_done(lat);
    n_cmp++;
    if (lat != 8 || out_sum !== 9'd7 || out_product !== 16'd12 || out_acc !== 16'd0) begin
      n_err++;
      $display("FAIL abort_next got lat=%0d sum=%0d prod=%0d acc=%0d want 8/7/12/0",
               lat, out_sum, out_product, out_acc);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero_operands();
    int lat;
    logic [7:0] av [2] = '{8'd0, 8'd255};
    logic [7:0] bv [2] = '{8'd255, 8'd0};
    for (int i = 0; i < 2; i++) begin
      send(av[i], bv[i], 1'b0);
      wait_done(lat);
      n_cmp++;
      if (lat != 8 || out_product !== 16'd0 || out_sum !== 9'd255) begin
        n_err++;
        $display("FAIL zero_op[%0d] got lat=%0d prod=%0d sum=%0d want 8/0/255",
                 i, lat, out_product, out_sum);
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_accumulate();
    test_clear_priority();
    test_abort();
    test_zero_operands();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
